// File: rtl/fifo_rd_sched_pkg.sv
// Shared definitions for the async-FIFO read-domain scheduler.
package fifo_rd_sched_pkg;

  localparam int ADDRSIZE = 4;  // FIFO address width
  localparam int DATASIZE = 8;  // FIFO word width
  localparam int BLW      = 3;  // burst-length field width

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rsched_state_t;

  // Decode a burst-length field into a word count; 0 stands for 2^BLW.
  function automatic logic [BLW:0] burst_words(input logic [BLW-1:0] len_field);
    return (len_field == '0) ? {1'b1, {BLW{1'b0}}} : {1'b0, len_field};
  endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// Combinational round-robin select: first set request after rr_ptr_i, modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   rr_ptr_i,
  output logic [PW-1:0]   pick_o,
  output logic            any_o
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk the requests starting one past the last served consumer.
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(rr_ptr_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        pick_o = idx;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-domain scheduler: round-robin grant of the single FIFO read port to
// NREQ consumers, bounded bursts, stall on empty/backpressure, abort on req drop.
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BLW-1:0]  len,
  input  logic [NREQ-1:0]      rd_ready,
  input  logic                 rempty,
  input  logic [DATASIZE-1:0]  rdata,
  output logic                 rinc,
  output logic [NREQ-1:0]      gnt,
  output logic                 rd_valid,
  output logic [DATASIZE-1:0]  rd_data,
  output logic                 rd_last,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  rsched_state_t   state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [BLW:0]    cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;   // index form of gnt_q, for rr_ptr update

  logic [PW-1:0]   pick;
  logic            any_req;
  logic [BLW-1:0]  len_sel;
  logic            req_g;
  logic            ready_g;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .any_o    (any_req)
  );

  // Handshake of the granted consumer only; gnt_q is zero outside a burst.
  assign req_g    = |(req & gnt_q);
  assign ready_g  = |(rd_ready & gnt_q);

  assign busy     = (state_q == BURST);
  assign rd_valid = busy && !rempty && req_g;
  assign rinc     = rd_valid && ready_g;
  assign rd_last  = rd_valid && (cnt_q == (BLW+1)'(1));
  assign rd_data  = rdata;
  assign gnt      = gnt_q;

  // Next-state logic: grant in IDLE, count down/abort in BURST.
  always_comb begin
    // NOTE: every variable is assigned a default first; a path that left one unassigned would infer a latch.
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    len_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PW'(i)) len_sel = len[i*BLW +: BLW];
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BURST;
          gnt_d   = NREQ'(1) << pick;
          gidx_d  = pick;
          cnt_d   = burst_words(len_sel);
        end
      end
      BURST: begin
        if (!req_g) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = gidx_q;
        end else if (rinc) begin
          cnt_d = cnt_q - (BLW+1)'(1);
          if (cnt_q == (BLW+1)'(1)) begin
            state_d  = IDLE;
            gnt_d    = '0;
            rr_ptr_d = gidx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves consumer 0 with first priority.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= PW'(NREQ - 1);
      gidx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed self-checking bench for fifo_rd_sched with a small FIFO read-side model.
module tb_fifo_rd_sched;
  import fifo_rd_sched_pkg::*;

  localparam int NREQ = 2;

  logic                rclk = 1'b0;
  logic                rrst;
  logic [NREQ-1:0]     req;
  logic [NREQ*BLW-1:0] len;
  logic [NREQ-1:0]     rd_ready;
  logic                rempty;
  logic [DATASIZE-1:0] rdata;
  logic                rinc;
  logic [NREQ-1:0]     gnt;
  logic                rd_valid;
  logic [DATASIZE-1:0] rd_data;
  logic                rd_last;
  logic                busy;

  int checks = 0;
  int errors = 0;

  // FIFO model: fill = words ever written, rd_cnt = words read by rinc.
  int   fill = 0;
  int   rd_cnt = 0;
  int   rinc_cnt = 0;
  logic force_empty = 1'b0;

  assign rempty = (fill == rd_cnt) || force_empty;
  assign rdata  = 8'h40 + rd_cnt[7:0];

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (rinc) begin
      rd_cnt   <= rd_cnt + 1;
      rinc_cnt <= rinc_cnt + 1;
    end
  end

  fifo_rd_sched #(.NREQ(NREQ)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .req      (req),
    .len      (len),
    .rd_ready (rd_ready),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .gnt      (gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge rclk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_gnt  [12];
    logic       exp_last [12];
    int         base;
    exp_gnt  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    rrst = 1'b1; req = '0; len = '0; rd_ready = 2'b11;
    #3;
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_rinc", rinc, 1'b0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_last", rd_last, 1'b0);
    cyc();
    rrst = 1'b0;

    // Single requester, len=3, five words in the FIFO
    fill = 5; req = 2'b01; len = {3'd0, 3'd3};
    #1 check("t1_idle_gnt", gnt, 2'b00);
    cyc(); #1;
    check("t1_c1_gnt", gnt, 2'b01);
    check("t1_c1_rinc", rinc, 1'b1);
    check("t1_c1_last", rd_last, 1'b0);
    check("t1_c1_data", rd_data, 8'h40);
    cyc(); #1;
    check("t1_c2_rinc", rinc, 1'b1);
    check("t1_c2_last", rd_last, 1'b0);
    check("t1_c2_data", rd_data, 8'h41);
    cyc(); #1;
    check("t1_c3_rinc", rinc, 1'b1);
    check("t1_c3_last", rd_last, 1'b1);
    check("t1_c3_data", rd_data, 8'h42);
    cyc();
    req = 2'b00; #1;
    check("t1_c4_busy", busy, 1'b0);
    check("t1_c4_gnt", gnt, 2'b00);
    check("t1_left", fill - rd_cnt, 2);

    // Fairness: both requesting, len 2 each, plenty of data; restart from reset priority
    rrst = 1'b1; #1 rrst = 1'b0;
    fill = rd_cnt + 50; req = 2'b11; len = {3'd2, 3'd2};
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("fair_gnt_%0d", k), gnt, exp_gnt[k]);
      check($sformatf("fair_rinc_%0d", k), rinc, exp_gnt[k] != 2'b00);
      check($sformatf("fair_last_%0d", k), rd_last, exp_last[k]);
      cyc();
    end
    req = 2'b00; #1;
    check("fair_end_busy", busy, 1'b0);

    // Empty stall: len=4, FIFO empty for 3 cycles after 2 words
    fill = rd_cnt + 20; req = 2'b01; len = {3'd0, 3'd4};
    cyc(); #1 check("es_c1_rinc", rinc, 1'b1);
    cyc(); #1 check("es_c2_rinc", rinc, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      force_empty = 1'b1; #1;
      check($sformatf("es_stall_rinc_%0d", k), rinc, 1'b0);
      check($sformatf("es_stall_valid_%0d", k), rd_valid, 1'b0);
      check($sformatf("es_stall_gnt_%0d", k), gnt, 2'b01);
      check($sformatf("es_stall_cnt_%0d", k), dut.cnt_q, 4'd2);
    end
    cyc();
    force_empty = 1'b0; #1;
    check("es_resume_valid", rd_valid, 1'b1);
    check("es_resume_rinc", rinc, 1'b1);
    check("es_resume_last", rd_last, 1'b0);
    cyc(); #1;
    check("es_final_rinc", rinc, 1'b1);
    check("es_final_last", rd_last, 1'b1);
    cyc();
    req = 2'b00; #1;
    check("es_end_busy", busy, 1'b0);

    // len=0 encodes 8 words; 10 available
    fill = rd_cnt + 10; req = 2'b01; len = {3'd0, 3'd0};
    base = rinc_cnt;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      check($sformatf("l0_rinc_%0d", k), rinc, 1'b1);
      check($sformatf("l0_last_%0d", k), rd_last, k == 7);
    end
    cyc();
    req = 2'b00; #1;
    check("l0_busy_end", busy, 1'b0);
    check("l0_pulses", rinc_cnt - base, 8);

    // Abort: consumer 1 drops req after one word
    fill = rd_cnt + 20; req = 2'b10; len = {3'd3, 3'd3};
    cyc(); #1;
    check("ab_gnt", gnt, 2'b10);
    check("ab_rinc1", rinc, 1'b1);
    cyc();
    req = 2'b00; #1;
    check("ab_drop_rinc", rinc, 1'b0);
    check("ab_drop_valid", rd_valid, 1'b0);
    cyc();
    req = 2'b11; #1;
    check("ab_idle_busy", busy, 1'b0);
    check("ab_idle_gnt", gnt, 2'b00);
    cyc(); #1;
    check("ab_rrptr_next_gnt", gnt, 2'b01);
    check("ab_next_rinc", rinc, 1'b1);

    // Reset mid-burst clears every output immediately
    rrst = 1'b1; #1;
    check("rm_gnt", gnt, 2'b00);
    check("rm_rinc", rinc, 1'b0);
    check("rm_valid", rd_valid, 1'b0);
    check("rm_last", rd_last, 1'b0);
    check("rm_busy", busy, 1'b0);
    req = 2'b00;
    #1 rrst = 1'b0;

    // Backpressure: rd_ready[0] toggles 1,0,1,0 with len=2
    req = 2'b01; len = {3'd0, 3'd2};
    base = rinc_cnt;
    cyc();
    rd_ready = 2'b11; #1;
    check("bp_c1_gnt", gnt, 2'b01);
    check("bp_c1_rinc", rinc, 1'b1);
    cyc();
    rd_ready = 2'b10; #1;
    check("bp_c2_rinc", rinc, 1'b0);
    check("bp_c2_valid", rd_valid, 1'b1);
    check("bp_c2_last", rd_last, 1'b1);
    cyc();
    rd_ready = 2'b11; #1;
    check("bp_c3_rinc", rinc, 1'b1);
    check("bp_c3_last", rd_last, 1'b1);
    cyc();
    rd_ready = 2'b10; req = 2'b00; #1;
    check("bp_c4_rinc", rinc, 1'b0);
    check("bp_c4_busy", busy, 1'b0);
    cyc();
    check("bp_pulses", rinc_cnt - base, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
